// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared opcodes, FSM encodings, queue entry type and static next-PC prediction
package ifetch_unit_pkg;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] pred;
  } fetch_entry_t;
  function automatic logic [31:0] imm_j(input logic [31:0] d);
    return {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] d);
    return {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
  endfunction
  // JALR targets are register-dependent and forward branches are predicted not-taken
  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] d);
    return (d[6:0] == OPC_JALR) ? pc + 32'd4 :
           (d[6:0] == OPC_JAL) ? pc + imm_j(d) :
           (d[6:0] == OPC_BRANCH && d[31]) ? pc + imm_b(d) : pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {word, pc, pred} entries; head reads 0 when empty
module fetch_queue
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[head];
  always_ff @(posedge clk) if (do_push) mem[tail] <= din;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop) head <= head + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC holder issuing one cache fetch at a time, predicting next PC and queueing words
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  output logic fetch_req,
  output logic [31:0] fetch_addr,
  input  logic fetch_idle,
  input  logic fetch_rsp_valid,
  input  logic [31:0] fetch_rsp_data,
  input  logic [31:0] fetch_rsp_addr,
  input  logic flush,
  input  logic [31:0] flush_pc,
  output logic inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pred_pc,
  input  logic inst_ready
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  logic [1:0] state;
  logic [31:0] pc, pending_addr, pred;
  logic [CW-1:0] count;
  logic full, empty, hit, issue;
  fetch_entry_t head;
  assign pred = predict(pending_addr, fetch_rsp_data);
  assign hit = state == S_WAIT && fetch_rsp_valid && fetch_rsp_addr == pending_addr;
  assign issue = state == S_IDLE && fetch_idle && count < CW'(QUEUE_DEPTH);
  assign inst_valid = ~empty;
  assign inst = head.word;
  assign inst_pc = head.pc;
  assign inst_pred_pc = head.pred;
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .push(rdy & ~flush & hit & ~full),
    .pop(rdy & ~flush & inst_ready),
    .clear(rdy & flush),
    .din('{word: fetch_rsp_data, pc: pending_addr, pred: pred}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // issue and hit are exclusive by state, so only flush and SETTLE need explicit priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      pending_addr <= '0;
      fetch_req <= 1'b0;
      fetch_addr <= '0;
    end else if (rdy) begin
      fetch_req <= 1'b0;
      if (flush) begin
        pc <= flush_pc;
        state <= S_SETTLE;
      end else if (state == S_SETTLE) begin
        state <= S_IDLE;
      end else if (issue) begin
        state <= S_WAIT;
        fetch_req <= 1'b1;
        fetch_addr <= pc;
        pending_addr <= pc;
      end else if (hit) begin
        state <= S_IDLE;
        pc <= pred;
      end
    end
  end
endmodule
